rf_access_arbiter: RTL and testbench
====================================

// Module: rf_access_arbiter
// PURPOSE
//  Shares the single register-file port (Address/WrEn/RdEn/WrData, RdData/RdData_Valid) between two masters:
//  requester 0 = system controller command path, requester 1 = secondary config/debug master.
//  Round-robin grant, one outstanding transaction, req/ack handshake, read data routed back to the granted master.
// PARAMETERS
//  DATA_WIDTH   8   register-file data width
//  ADDR         4   register-file address width
//  TIMEOUT_CYC  16  max cycles waiting for RdData_Valid (used only with RF_ARB_TIMEOUT_EN)
// PORTS
//  CLK          in   1               single clock, all logic posedge
//  RST          in   1               synchronous, active-high reset
//  req          in   2               per-requester request, held until ack
//  req_wr       in   2               per-requester 1=write, 0=read
//  req_addr     in   2*ADDR          {addr1,addr0}
//  req_wdata    in   2*DATA_WIDTH    {wdata1,wdata0}
//  ack          out  2               one-cycle pulse: transaction complete for that requester
//  rsp_data     out  DATA_WIDTH      read data (shared bus), valid with rsp_valid
//  rsp_valid    out  2               one-cycle pulse per requester with read result
//  rsp_err      out  1               read timed out (qualified by rsp_valid)
//  Address      out  ADDR            register-file address
//  WrEn         out  1               register-file write strobe
//  RdEn         out  1               register-file read strobe
//  WrData       out  DATA_WIDTH      register-file write data
//  RdData       in   DATA_WIDTH      register-file read data
//  RdData_Valid in   1               register-file read data valid
// BEHAVIOUR
//  - All outputs registered. Reset (RST=1 at posedge): state IDLE, every output 0, rr pointer -> requester 0 favoured.
//  - States: IDLE -> ISSUE -> (write) IDLE | (read) WAIT_RD -> IDLE.
//  - IDLE: if any req, pick grant; latch addr/wdata/wr of winner; -> ISSUE. No req: stay, outputs 0.
//  - Arbitration: single req wins; both req -> the one NOT granted last; after reset requester 0 wins first tie.
//  - ISSUE (1 cycle): drive Address/WrData and WrEn or RdEn high for exactly this cycle.
//    Write: ack[g]=1 same cycle, -> IDLE. Read: -> WAIT_RD, strobes drop next cycle.
//  - WAIT_RD: on RdData_Valid, next cycle rsp_data=RdData, rsp_valid[g]=1, ack[g]=1, rsp_err=0, -> IDLE.
//  - Latency (req seen at cycle 0): write strobe+ack cycle 1; read RdEn cycle 1, resp = RdData_Valid cycle + 1.
//  - Back-to-back: requester may keep req high after ack for a new command; re-sampled in IDLE (min 2 cycles/write).
//  - Last-grant pointer updates when ack issues; alternates fairly under continuous dual requests.
//  - RdData_Valid outside WAIT_RD ignored. req dropped before ack: protocol violation, transaction still completes.
//  - Non-granted req never acked; its inputs are not sampled until granted.
//  - rsp_data holds last value between responses; rsp_valid/ack/WrEn/RdEn are strictly one-cycle pulses.
//  - Reset asserted mid-transaction: abort immediately, no ack/rsp emitted, return to IDLE with reset values.
// CONFIGURATION
//  RF_ARB_TIMEOUT_EN defined: counter loads 0 on entry to WAIT_RD, increments each cycle; when it reaches
//    TIMEOUT_CYC without RdData_Valid -> next cycle rsp_valid[g]=1, ack[g]=1, rsp_err=1, rsp_data=0, -> IDLE.
//    RdData_Valid on the expiry cycle wins (normal response, rsp_err=0).
//  RF_ARB_TIMEOUT_EN undefined: no counter; WAIT_RD waits indefinitely; rsp_err tied 0.
// TESTING
//  1. Only req[0], write addr 4'h3 data 8'h5A -> cycle1 WrEn=1 Address=3 WrData=5A, ack=2'b01; nothing else.
//  2. Only req[1], read addr 4'h2, RdData=8'hC3 valid 1 cycle after RdEn -> rsp_valid=2'b10, rsp_data=C3, err=0.
//  3. Both req continuously writing after reset -> grants 0,1,0,1...; no requester acked twice in a row.
//  4. Read with RdData_Valid never asserted, macro on -> ack+rsp_valid after TIMEOUT_CYC+1, rsp_err=1, data=0;
//     macro off -> stays in WAIT_RD, no ack for 100 cycles.
//  5. RST pulsed during WAIT_RD -> all outputs 0 next cycle, late RdData_Valid ignored, next tie grants req 0.
//  6. Stray RdData_Valid in IDLE/ISSUE -> no rsp_valid, no state change.

Source files
------------

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: round-robin sharing of one register-file port by two masters.
// Optional read timeout is enabled by defining RF_ARB_TIMEOUT_EN.
module rf_access_arbiter #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR        = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [1:0]              req,
   input  logic [1:0]              req_wr,
   input  logic [2*ADDR-1:0]       req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              ack,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic [1:0]              rsp_valid,
   output logic                    rsp_err,
   output logic [ADDR-1:0]         Address,
   output logic                    WrEn,
   output logic                    RdEn,
   output logic [DATA_WIDTH-1:0]   WrData,
   input  logic [DATA_WIDTH-1:0]   RdData,
   input  logic                    RdData_Valid
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

   state_t                state, state_nxt;
   logic                  gnt, gnt_nxt;
   logic                  last, last_nxt;
   logic                  win;
   logic [1:0]            ack_nxt, rv_nxt;
   logic [ADDR-1:0]       addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_nxt, rdata_nxt;
   logic                  wren_nxt, rden_nxt;

`ifdef RF_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt, cnt_nxt;
   logic          err_nxt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= '0;
         rsp_err <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         rsp_err <= err_nxt;
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         last      <= 1'b1;
         ack       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         Address   <= '0;
         WrData    <= '0;
         WrEn      <= 1'b0;
         RdEn      <= 1'b0;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         last      <= last_nxt;
         ack       <= ack_nxt;
         rsp_valid <= rv_nxt;
         rsp_data  <= rdata_nxt;
         Address   <= addr_nxt;
         WrData    <= wdata_nxt;
         WrEn      <= wren_nxt;
         RdEn      <= rden_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      last_nxt  = last;
      win       = 1'b0;
      ack_nxt   = '0;
      rv_nxt    = '0;
      addr_nxt  = '0;
      wdata_nxt = '0;
      wren_nxt  = 1'b0;
      rden_nxt  = 1'b0;
      rdata_nxt = rsp_data;
`ifdef RF_ARB_TIMEOUT_EN
      cnt_nxt   = cnt;
      err_nxt   = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (|req) begin
               // tie goes to whoever was not acked last
               win       = (req == 2'b11) ? ~last : req[1];
               gnt_nxt   = win;
               addr_nxt  = win ? req_addr[2*ADDR-1:ADDR]
                               : req_addr[ADDR-1:0];
               wdata_nxt = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : req_wdata[DATA_WIDTH-1:0];
               wren_nxt  = req_wr[win];
               rden_nxt  = ~req_wr[win];
               if (req_wr[win]) begin
                  ack_nxt[win] = 1'b1;
                  last_nxt     = win;
               end
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            state_nxt = WrEn ? IDLE : WAIT_RD;
`ifdef RF_ARB_TIMEOUT_EN
            cnt_nxt   = '0;
`endif
         end
         WAIT_RD: begin
            if (RdData_Valid) begin
               rdata_nxt    = RdData;
               rv_nxt[gnt]  = 1'b1;
               ack_nxt[gnt] = 1'b1;
               last_nxt     = gnt;
               state_nxt    = IDLE;
            end
`ifdef RF_ARB_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT_CYC)) begin
               rdata_nxt    = '0;
               rv_nxt[gnt]  = 1'b1;
               ack_nxt[gnt] = 1'b1;
               err_nxt      = 1'b1;
               last_nxt     = gnt;
               state_nxt    = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed and randomized checks for rf_access_arbiter.
// Bench plays both masters and the register file; expectations come from a transaction model.
module tb_rf_access_arbiter;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 16;

   logic          CLK = 1'b0;
   logic          RST;
   logic [1:0]    req, req_wr, ack, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [DW-1:0] rsp_data, WrData, RdData;
   logic          rsp_err, WrEn, RdEn, RdData_Valid;
   logic [AW-1:0] Address;

   int checks = 0;
   int errors = 0;
   bit last_m;
   logic [DW-1:0] rf [16];

   always #5 CLK = ~CLK;

   rf_access_arbiter #(.DATA_WIDTH(DW), .ADDR(AW), .TIMEOUT_CYC(TO)) dut (
      .CLK(CLK), .RST(RST), .req(req), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
      .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
      .RdData(RdData), .RdData_Valid(RdData_Valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic chk_pulses(input string tag, input logic [1:0] a,
                             input logic [1:0] v, input logic we,
                             input logic re);
      chk({tag, ".ack"}, 32'(ack), 32'(a));
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
      chk({tag, ".WrEn"}, 32'(WrEn), 32'(we));
      chk({tag, ".RdEn"}, 32'(RdEn), 32'(re));
   endtask

   task automatic chk_zero(input string tag);
      chk_pulses(tag, 2'b00, 2'b00, 1'b0, 1'b0);
      chk({tag, ".Address"}, 32'(Address), 0);
      chk({tag, ".WrData"}, 32'(WrData), 0);
      chk({tag, ".rsp_data"}, 32'(rsp_data), 0);
      chk({tag, ".rsp_err"}, 32'(rsp_err), 0);
   endtask

   task automatic set_lane(input int r, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_wr[r] = wr;
      req_addr[r*AW +: AW] = a;
      req_wdata[r*DW +: DW] = d;
   endtask

   task automatic run_random(input int n);
      bit pend [2];
      bit cwr [2];
      logic [AW-1:0] ca [2];
      logic [DW-1:0] cd [2];
      bit busy, cur, rd_wait, ackwr, g, strobe;
      int sample_ok, valid_at, resp_at, nacks;
      logic [DW-1:0] last_rsp, exp_rd;
      logic [1:0] exp_ack, exp_rv;
      pend[0] = 1'b0; pend[1] = 1'b0;
      cwr[0] = 1'b0; cwr[1] = 1'b0;
      ca[0] = '0; ca[1] = '0;
      cd[0] = '0; cd[1] = '0;
      busy = 1'b0; cur = 1'b0; rd_wait = 1'b0; g = 1'b0;
      sample_ok = -1; valid_at = -1; resp_at = -1; nacks = 0;
      last_rsp = '0; exp_rd = '0;
      for (int k = 0; k < n; k++) begin
         cyc();
         exp_ack = '0;
         exp_rv = '0;
         strobe = !busy && (k > sample_ok) && (pend[0] || pend[1]);
         chk("rnd.strobe", 32'(WrEn | RdEn), 32'(strobe));
         if (strobe) begin
            g = (pend[0] && pend[1]) ? ~last_m : pend[1];
            chk("rnd.kind", 32'(WrEn), 32'(cwr[g]));
            chk("rnd.addr", 32'(Address), 32'(ca[g]));
            if (cwr[g]) chk("rnd.wdata", 32'(WrData), 32'(cd[g]));
            busy = 1'b1;
            cur = g;
            if (cwr[g]) begin
               rf[ca[g]] = cd[g];
               exp_ack[g] = 1'b1;
            end else begin
               rd_wait = 1'b1;
               valid_at = k + int'($urandom_range(1, 4));
            end
         end
         if (k == resp_at) begin
            exp_ack[cur] = 1'b1;
            exp_rv[cur] = 1'b1;
            last_rsp = exp_rd;
         end
         chk("rnd.ack", 32'(ack), 32'(exp_ack));
         chk("rnd.rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         chk("rnd.rsp_data", 32'(rsp_data), 32'(last_rsp));
         chk("rnd.rsp_err", 32'(rsp_err), 0);
         if (exp_ack != 2'b00) begin
            ackwr = cwr[cur];
            pend[cur] = 1'b0;
            req[cur] = 1'b0;
            last_m = cur;
            busy = 1'b0;
            nacks++;
            sample_ok = ackwr ? k + 1 : k;
         end
         RdData_Valid = 1'b0;
         if (rd_wait && k == valid_at) begin
            exp_rd = rf[ca[cur]];
            RdData = exp_rd;
            RdData_Valid = 1'b1;
            rd_wait = 1'b0;
            resp_at = k + 1;
         end else if (!rd_wait && $urandom_range(0, 7) == 0) begin
            RdData = DW'($urandom);
            RdData_Valid = 1'b1;
         end
         for (int r = 0; r < 2; r++) begin
            if (!pend[r]) begin
               cwr[r] = 1'($urandom);
               ca[r] = AW'($urandom);
               cd[r] = DW'($urandom);
               set_lane(r, cwr[r], ca[r], cd[r]);
               if ($urandom_range(0, 2) == 0) begin
                  pend[r] = 1'b1;
                  req[r] = 1'b1;
               end
            end
         end
      end
      chk("rnd.progress", 32'(nacks > n / 8), 1);
   endtask

   initial begin
      logic [AW-1:0] ta [2];
      logic [DW-1:0] td [2];
      bit g;
      RST = 1'b1;
      req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      RdData = '0; RdData_Valid = 1'b0;
      for (int i = 0; i < 16; i++) rf[i] = '0;
      cyc();
      cyc();
      chk_zero("reset");
      RST = 1'b0;
      last_m = 1'b1;

      // single write from requester 0
      set_lane(0, 1'b1, 4'h3, 8'h5A);
      set_lane(1, 1'b0, 4'hF, 8'hFF);
      req = 2'b01;
      cyc();
      chk_pulses("t1", 2'b01, 2'b00, 1'b1, 1'b0);
      chk("t1.addr", 32'(Address), 3);
      chk("t1.wdata", 32'(WrData), 32'h5A);
      req = 2'b00;
      cyc();
      chk_pulses("t1.after", 2'b00, 2'b00, 1'b0, 1'b0);

      // single read from requester 1
      set_lane(1, 1'b0, 4'h2, 8'h00);
      set_lane(0, 1'b1, 4'h9, 8'h99);
      req = 2'b10;
      cyc();
      chk_pulses("t2.issue", 2'b00, 2'b00, 1'b0, 1'b1);
      chk("t2.addr", 32'(Address), 2);
      cyc();
      chk_pulses("t2.wait", 2'b00, 2'b00, 1'b0, 1'b0);
      RdData = 8'hC3;
      RdData_Valid = 1'b1;
      cyc();
      chk_pulses("t2.rsp", 2'b10, 2'b10, 1'b0, 1'b0);
      chk("t2.data", 32'(rsp_data), 32'hC3);
      chk("t2.err", 32'(rsp_err), 0);
      req = 2'b00;
      RdData_Valid = 1'b0;
      RdData = 8'h00;
      cyc();
      chk_pulses("t2.after", 2'b00, 2'b00, 1'b0, 1'b0);
      chk("t2.hold", 32'(rsp_data), 32'hC3);
      last_m = 1'b1;

      // continuous dual writes alternate
      ta[0] = 4'h4; td[0] = 8'h40;
      ta[1] = 4'h8; td[1] = 8'h80;
      set_lane(0, 1'b1, ta[0], td[0]);
      set_lane(1, 1'b1, ta[1], td[1]);
      req = 2'b11;
      for (int i = 0; i < 8; i++) begin
         g = ~last_m;
         cyc();
         chk_pulses("t3.strobe", g ? 2'b10 : 2'b01, 2'b00, 1'b1, 1'b0);
         chk("t3.addr", 32'(Address), 32'(ta[g]));
         chk("t3.wdata", 32'(WrData), 32'(td[g]));
         last_m = g;
         ta[g] = AW'($urandom);
         td[g] = DW'($urandom);
         set_lane(int'(g), 1'b1, ta[g], td[g]);
         cyc();
         chk_pulses("t3.gap", 2'b00, 2'b00, 1'b0, 1'b0);
      end
      req = 2'b00;
      cyc();

      // stray RdData_Valid in IDLE and ISSUE
      RdData = 8'h77;
      RdData_Valid = 1'b1;
      cyc();
      chk_pulses("t6.idle", 2'b00, 2'b00, 1'b0, 1'b0);
      cyc();
      chk_pulses("t6.idle2", 2'b00, 2'b00, 1'b0, 1'b0);
      chk("t6.hold", 32'(rsp_data), 32'hC3);
      set_lane(0, 1'b1, 4'h1, 8'h11);
      req = 2'b01;
      cyc();
      chk_pulses("t6.wr", 2'b01, 2'b00, 1'b1, 1'b0);
      req = 2'b00;
      cyc();
      chk_pulses("t6.wr.after", 2'b00, 2'b00, 1'b0, 1'b0);
      set_lane(0, 1'b0, 4'h6, 8'h00);
      req = 2'b01;
      cyc();
      chk_pulses("t6.rd.issue", 2'b00, 2'b00, 1'b0, 1'b1);
      RdData_Valid = 1'b0;
      cyc();
      chk_pulses("t6.rd.wait", 2'b00, 2'b00, 1'b0, 1'b0);
      chk("t6.rd.hold", 32'(rsp_data), 32'hC3);
      RdData = 8'h3C;
      RdData_Valid = 1'b1;
      cyc();
      chk_pulses("t6.rd.rsp", 2'b01, 2'b01, 1'b0, 1'b0);
      chk("t6.rd.data", 32'(rsp_data), 32'h3C);
      req = 2'b00;
      RdData_Valid = 1'b0;
      cyc();
      chk_pulses("t6.rd.after", 2'b00, 2'b00, 1'b0, 1'b0);

      // read that never gets RdData_Valid
      set_lane(0, 1'b0, 4'h5, 8'h00);
      req = 2'b01;
      cyc();
      chk_pulses("t4.issue", 2'b00, 2'b00, 1'b0, 1'b1);
`ifdef RF_ARB_TIMEOUT_EN
      for (int j = 2; j <= TO + 2; j++) begin
         cyc();
         chk_pulses("t4.wait", 2'b00, 2'b00, 1'b0, 1'b0);
      end
      cyc();
      chk_pulses("t4.timeout", 2'b01, 2'b01, 1'b0, 1'b0);
      chk("t4.err", 32'(rsp_err), 1);
      chk("t4.data", 32'(rsp_data), 0);
      req = 2'b00;
      cyc();
      chk_pulses("t4.after", 2'b00, 2'b00, 1'b0, 1'b0);
      chk("t4.err.after", 32'(rsp_err), 0);
      set_lane(1, 1'b0, 4'h7, 8'h00);
      req = 2'b10;
      cyc();
      chk_pulses("t5.issue", 2'b00, 2'b00, 1'b0, 1'b1);
      cyc();
      cyc();
`else
      for (int j = 0; j < 100; j++) begin
         cyc();
         chk_pulses("t4.wait", 2'b00, 2'b00, 1'b0, 1'b0);
      end
`endif

      // reset while waiting for read data
      RST = 1'b1;
      req = 2'b00;
      cyc();
      RST = 1'b0;
      last_m = 1'b1;
      chk_zero("t5.rst");
      RdData = 8'hAB;
      RdData_Valid = 1'b1;
      cyc();
      chk_pulses("t5.late", 2'b00, 2'b00, 1'b0, 1'b0);
      chk("t5.late.data", 32'(rsp_data), 0);
      RdData_Valid = 1'b0;
      set_lane(0, 1'b1, 4'hC, 8'hC0);
      set_lane(1, 1'b1, 4'hD, 8'hD0);
      req = 2'b11;
      cyc();
      chk_pulses("t5.tie", 2'b01, 2'b00, 1'b1, 1'b0);
      chk("t5.tie.addr", 32'(Address), 32'hC);
      req = 2'b00;
      cyc();
      chk_pulses("t5.after", 2'b00, 2'b00, 1'b0, 1'b0);

      // randomized traffic against the transaction model
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      last_m = 1'b1;
      chk_zero("rnd.reset");
      run_random(1500);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
